// File: rtl/layer_serializer.sv
// layer_serializer: captures one layer's parallel output vector in a single
// handshake and replays it one neuron per valid/ready transfer.
// Ports: i_clk, i_rst_n (sync, active-low); i_layer_data/i_layer_valid/
// o_layer_ready parallel input; o_data/o_valid/o_neuron_id/o_layer_id/i_ready
// serial output; o_done pulses once per finished vector.
// Option: LAYER_SERIALIZER_PRELOAD_EN adds a shadow buffer so the next
// vector can be accepted while the current one is still being sent.
module layer_serializer #(
   parameter int LAYER_ID   = 1,
   parameter int NUM_NEURON = 30,
   parameter int DATA_WIDTH = 16
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_layer_data,
   input  logic                             i_layer_valid,
   output logic                             o_layer_ready,
   output logic [DATA_WIDTH-1:0]            o_data,
   output logic                             o_valid,
   output logic [31:0]                      o_neuron_id,
   output logic [31:0]                      o_layer_id,
   input  logic                             i_ready,
   output logic                             o_done
);

   localparam int IW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_NEURON - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] vec   [NUM_NEURON];
   logic [DATA_WIDTH-1:0] act_q [NUM_NEURON];
   logic [DATA_WIDTH-1:0] act_d [NUM_NEURON];

   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  lready_q, lready_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [31:0]           nid_q, nid_d;
   logic [31:0]           lid_q, lid_d;

   logic                  xfer;
   logic                  take;

`ifdef LAYER_SERIALIZER_PRELOAD_EN
   logic [DATA_WIDTH-1:0] shd_q [NUM_NEURON];
   logic [DATA_WIDTH-1:0] shd_d [NUM_NEURON];
   logic                  sfull_q, sfull_d;
`endif

   always_comb begin
      for (int n = 0; n < NUM_NEURON; n++)
         vec[n] = i_layer_data[n*DATA_WIDTH +: DATA_WIDTH];
   end

   assign xfer = valid_q & i_ready;
   assign take = i_layer_valid & lready_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      act_d   = act_q;
`ifdef LAYER_SERIALIZER_PRELOAD_EN
      shd_d   = shd_q;
      sfull_d = sfull_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (take) begin
               act_d   = vec;
               idx_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (xfer) begin
               if (idx_q == LAST) state_d = S_DONE;
               else               idx_d   = idx_q + 1'b1;
            end
`ifdef LAYER_SERIALIZER_PRELOAD_EN
            if (take) begin
               shd_d   = vec;
               sfull_d = 1'b1;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
`ifdef LAYER_SERIALIZER_PRELOAD_EN
            // ready is low while the shadow is full, so the two
            // branches cannot both apply
            if (sfull_q) begin
               act_d   = shd_q;
               sfull_d = 1'b0;
               idx_d   = '0;
               state_d = S_SEND;
            end else if (take) begin
               act_d   = vec;
               idx_d   = '0;
               state_d = S_SEND;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // outputs are registered images of the next state
   always_comb begin
      valid_d  = (state_d == S_SEND);
      done_d   = (state_d == S_DONE);
`ifdef LAYER_SERIALIZER_PRELOAD_EN
      lready_d = (state_d == S_IDLE) | ~sfull_d;
`else
      lready_d = (state_d == S_IDLE);
`endif
      data_d   = valid_d ? act_d[idx_d] : '0;
      nid_d    = valid_d ? 32'(idx_d) : '0;
      lid_d    = valid_d ? 32'(LAYER_ID) : '0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         lready_q <= 1'b1;
         data_q   <= '0;
         nid_q    <= '0;
         lid_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         lready_q <= lready_d;
         data_q   <= data_d;
         nid_q    <= nid_d;
         lid_q    <= lid_d;
      end
   end

   // vector storage needs no reset; state decides if it is meaningful
   always_ff @(posedge i_clk) begin
      act_q <= act_d;
   end

`ifdef LAYER_SERIALIZER_PRELOAD_EN
   always_ff @(posedge i_clk) begin
      shd_q <= shd_d;
      if (!i_rst_n) sfull_q <= 1'b0;
      else          sfull_q <= sfull_d;
   end
`endif

   assign o_valid       = valid_q;
   assign o_done        = done_q;
   assign o_layer_ready = lready_q;
   assign o_data        = data_q;
   assign o_neuron_id   = nid_q;
   assign o_layer_id    = lid_q;

endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Transmit end of the inter-layer serial neuron-output interface.
- Captures the full parallel output vector of one layer in a single handshake, then presents it one neuron per transfer to the next layer.
- Drives o_neuron_id and o_layer_id. Consumes the single selected ready bit (per-neuron ready indexed by neuron id, gated by layer id match) on i_ready.

Parameters:
- LAYER_ID, 1: value driven on o_layer_id while a transfer is offered.
- NUM_NEURON, 30: neurons in the source layer; number of serial transfers per vector (min 1).
- DATA_WIDTH, 16: bits per neuron output.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_layer_data  input  NUM_NEURON*DATA_WIDTH  parallel layer outputs; neuron n at bits [n*DATA_WIDTH +: DATA_WIDTH].
- i_layer_valid  input  1  parallel vector valid.
- o_layer_ready  output  1  block can accept a vector.
- o_data  output  DATA_WIDTH  current neuron output.
- o_valid  output  1  o_data/o_neuron_id valid.
- o_neuron_id  output  32  index of neuron on o_data.
- o_layer_id  output  32  LAYER_ID while o_valid=1, else 0.
- i_ready  input  1  selected next-layer ready.
- o_done  output  1  one-cycle pulse after last neuron of a vector transferred.

Behaviour:
- Reset (i_rst_n=0 at a rising edge), values held from the following cycle:
  - o_valid=0, o_done=0, o_layer_ready=1, o_data=0, o_neuron_id=0, o_layer_id=0.
  - Index cleared; buffer contents discarded.
- Reset mid-transfer aborts the vector. No o_done pulse.
- All outputs registered. The only combinational path is none: o_layer_ready is registered.
- FSM states IDLE, SEND, DONE.
- IDLE:
  - o_layer_ready=1, o_valid=0.
  - Capture when i_layer_valid & o_layer_ready: latch the whole vector, idx=0, go to SEND.
  - First o_valid appears the cycle after capture (latency 1).
- SEND:
  - o_layer_ready=0, o_valid=1, o_data=buf[idx], o_neuron_id=idx, o_layer_id=LAYER_ID.
  - Transfer occurs on o_valid & i_ready at an edge.
  - On transfer with idx<NUM_NEURON-1: idx+1. The next neuron is shown in the following cycle, so back-to-back transfers are possible at 1 per cycle.
  - On transfer with idx==NUM_NEURON-1: go to DONE.
  - Without a transfer, all outputs hold stable (AXI-style). o_valid never drops before the transfer.
- DONE:
  - One cycle only: o_done=1, o_valid=0, o_layer_id=0, o_neuron_id=0, o_layer_ready=0.
  - Next state is IDLE.
- Index: counter of width $clog2(NUM_NEURON) (min 1), zero-extended onto o_neuron_id. It never wraps past NUM_NEURON-1.
- NUM_NEURON=1: capture, one SEND cycle-set, then DONE.
- i_layer_valid while o_layer_ready=0 is ignored; the upstream source must hold it.
- i_ready while o_valid=0 is ignored.

Optional Feature:
- Macro: LAYER_SERIALIZER_PRELOAD_EN.
- Defined:
  - Adds a second (shadow) vector buffer.
  - In SEND and DONE, o_layer_ready = shadow empty. i_layer_valid & o_layer_ready loads the shadow buffer.
  - On leaving DONE with shadow full: move shadow to the active buffer, idx=0, go straight to SEND, skipping IDLE.
  - o_done still pulses once per vector.
  - A capture in the same cycle as leaving DONE loads the active buffer directly.
  - Reset clears the shadow.
- Undefined: single buffer; behaviour exactly as above.

Test Plan (NUM_NEURON=4, DATA_WIDTH=8, LAYER_ID=2):
- Reset check: hold i_rst_n=0 for 2 cycles, release -> o_valid=0, o_done=0, o_layer_ready=1, o_layer_id=0, o_neuron_id=0.
- Full-rate send:
  - Stimulus: capture {0x44,0x33,0x22,0x11} (neuron0=0x11), i_ready=1 constant.
  - Required: cycles 1-4 show o_data 0x11,0x22,0x33,0x44 with o_neuron_id 0,1,2,3 and o_layer_id=2; cycle 5 o_done=1; cycle 6 o_layer_ready=1.
- Backpressure:
  - Stimulus: i_ready=0 for 3 cycles at neuron 1, then 1.
  - Required: o_data=0x22 and o_neuron_id=1 stable with o_valid=1 throughout; no neuron skipped; o_done once.
- Ignored vector: i_layer_valid=1 with a new vector during SEND -> not captured; the original vector completes unchanged.
- Mid-transfer reset: i_rst_n=0 at neuron 2 -> next cycle o_valid=0, no o_done; a new capture then restarts at o_neuron_id=0.
- PRELOAD (macro defined):
  - Stimulus: second vector {0xDD,0xCC,0xBB,0xAA} offered during first send.
  - Required: accepted while o_valid=1; after o_done, o_valid=1 with 0xAA at o_neuron_id=0 the next cycle; two o_done pulses total.
